hqb_job_sched: RTL and testbench
================================

# hqb_job_sched

Round-robin job scheduler and sequencer for the shared H·B complex dot-product datapath: the two Q8.8 complex multipliers and the adder pair feeding the column collector. It grants the datapath to one of NREQ requesters at a time; each requester owns one B-matrix LUT. For each granted job it walks every (B column, H row) address pair, tracks the fixed datapath latency, emits indexed capture strobes to the collector, and signals per-requester completion. It replaces the free-running start counter, so that jobs run only on demand.

## Interface
Parameters:
- NREQ, 4, number of requesters / B-matrix tables (2..8)
- NROW, 4, H rows per column (power of 2)
- NCOL, 2, B columns per job (power of 2)
- LAT, 4, cycles from address issue to valid adder output (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  level job request per requester
- grant  out  NREQ  one-hot owner of the datapath, held for the whole job
- done  out  NREQ  one-cycle completion pulse to the owner
- busy  out  1  job in progress (grant != 0)
- bsel  out  clog2(NREQ)  B-table select, equals index of the granted requester
- addr_rowH  out  clog2(NROW)  H row address to the LUT
- addr_colB  out  max(1,clog2(NCOL))  B column address to the LUT
- issue_vld  out  1  addresses valid this cycle
- cap_vld  out  1  datapath output (out_r/out_i) valid this cycle, to be written by the collector
- cap_row  out  clog2(NROW)  element index of the capture
- cap_col  out  max(1,clog2(NCOL))  column index of the capture

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE. All outputs registered.
- IDLE: if any req bit is set, select the first set bit at or above rr_ptr, wrapping round. Register grant/bsel and move to ISSUE. If no bit is set, stay.
- ISSUE: issue_vld=1 for exactly NROW·NCOL cycles in column-major order: (col0,row0..NROW-1), then col1, and so on. After the last pair go to DRAIN.
- Capture tracking: issue_vld, row and col go into a LAT-deep delay line. Its output drives cap_vld/cap_row/cap_col. Captures therefore occur in issue order.
- DRAIN: wait until the last capture has been output, then go to DONE.
- DONE: one cycle with done[owner]=1 and grant=0. Set rr_ptr = (owner+1) mod NREQ, then go to IDLE.
- Requests are sampled only in IDLE. Deasserting req mid-job does not abort the job. A requester whose req is still high after done is re-arbitrated normally.
- bsel holds its last value when idle. addr_rowH and addr_colB are 0 when issue_vld=0.
- rst at any time: state IDLE, delay line cleared, rr_ptr=0, all outputs 0. No done pulse is emitted for an aborted job.

## Timing
- Reset values: grant=0, done=0, busy=0, bsel=0, addr_rowH=0, addr_colB=0, issue_vld=0, cap_vld=0, cap_row=0, cap_col=0.
- Let N = NROW·NCOL and let req be sampled in IDLE at edge E0:
  - cycle 1 (after E0): grant/busy high, first issue.
  - issue cycles 1..N.
  - capture k (k=1..N) occurs in cycle k+LAT.
  - done pulse in cycle N+LAT+1, with grant=0 and busy=0.
  - earliest next grant is cycle N+LAT+2.
- Defaults (N=8, LAT=4): issue 1–8, captures 5–12, done 13, next grant 14.
- Simultaneous requests: exactly one grant. The others wait with no starvation; worst-case wait is (NREQ-1) jobs.

## Test plan
- Single job: req=0001 held, defaults → grant=0001 cycle 1, addresses (0,0)…(1,3) cycles 1–8, cap_vld cycles 5–12 with matching (col,row), done=0001 cycle 13 only.
- Round robin: req=1111 held from reset → grants in order 0001, 0010, 0100, 1000, 0001, each job 13 cycles, one idle cycle between jobs, bsel = 0, 1, 2, 3, 0.
- Pointer wrap: rr_ptr=3 after a job for requester 2, req=0101 → grant 0001, because bit 3 is clear and arbitration wraps to bit 0.
- Req dropped: req=0010 pulsed for one cycle → full job completes, done=0010 at cycle 13, then stays IDLE.
- Reset mid-job: rst asserted in cycle 6 → next cycle all outputs 0, no cap_vld or done afterwards; a new req after reset gets grant with bsel starting from rr_ptr=0.
- LAT=1 build: captures in cycles 2–9, done in cycle 10; cap indices equal the previous cycle's addresses.

Source files
------------

// File: rtl/hqb_job_sched.sv
// Round-robin job scheduler for the shared H*B dot-product datapath.
// Walks (col,row) address pairs per job and times the capture strobes.
module hqb_job_sched #(
  parameter int NREQ = 4,
  parameter int NROW = 4,
  parameter int NCOL = 2,
  parameter int LAT  = 4,
  localparam int BW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int RW  = (NROW > 1) ? $clog2(NROW) : 1,
  localparam int CW  = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [BW-1:0]   bsel,
  output logic [RW-1:0]   addr_rowH,
  output logic [CW-1:0]   addr_colB,
  output logic            issue_vld,
  output logic            cap_vld,
  output logic [RW-1:0]   cap_row,
  output logic [CW-1:0]   cap_col
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] w_grant_nxt;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] w_done_nxt;
  logic [BW-1:0]   r_bsel;
  logic [BW-1:0]   w_bsel_nxt;
  logic [BW-1:0]   r_ptr;
  logic [BW-1:0]   w_ptr_nxt;
  logic            r_issue;
  logic            w_issue_nxt;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   w_row_nxt;
  logic [CW-1:0]   r_col;
  logic [CW-1:0]   w_col_nxt;

  logic            r_dl_vld [LAT];
  logic [RW-1:0]   r_dl_row [LAT];
  logic [CW-1:0]   r_dl_col [LAT];

  logic [BW-1:0]   w_owner_inc;
  logic [BW-1:0]   w_arb_base;
  logic            w_arb_hit;
  logic [BW-1:0]   w_arb_idx;
  logic [NREQ-1:0] w_arb_oh;
  logic            w_hi_hit;
  logic [BW-1:0]   w_hi_idx;
  logic            w_lo_hit;
  logic [BW-1:0]   w_lo_idx;
  logic            w_row_end;
  logic            w_last;
  logic            w_cap_last;

  localparam logic [BW-1:0] LastReq = BW'(NREQ - 1);
  localparam logic [RW-1:0] LastRow = RW'(NROW - 1);
  localparam logic [CW-1:0] LastCol = CW'(NCOL - 1);

  // The done cycle already arbitrates with the advanced pointer,
  // so a waiting requester is granted right after the pulse.
  assign w_owner_inc = (r_bsel == LastReq) ? '0 : r_bsel + 1'b1;
  assign w_arb_base  = (r_state == S_DONE) ? w_owner_inc : r_ptr;

  // Lowest set bit at/above the pointer, else lowest set bit overall.
  always_comb begin
    w_hi_hit = 1'b0;
    w_hi_idx = '0;
    w_lo_hit = 1'b0;
    w_lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_hit = 1'b1;
        w_lo_idx = BW'(i);
        if (BW'(i) >= w_arb_base) begin
          w_hi_hit = 1'b1;
          w_hi_idx = BW'(i);
        end
      end
    end
    w_arb_hit = w_lo_hit;
    w_arb_idx = w_hi_hit ? w_hi_idx : w_lo_idx;
  end

  assign w_arb_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_arb_idx;
  assign w_row_end = (r_row == LastRow);
  assign w_last    = w_row_end && (r_col == LastCol);
  assign w_cap_last = r_dl_vld[LAT-1]
                   && (r_dl_row[LAT-1] == LastRow)
                   && (r_dl_col[LAT-1] == LastCol);

  // Next-state and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_bsel_nxt  = r_bsel;
    w_ptr_nxt   = r_ptr;
    w_issue_nxt = r_issue;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_grant_nxt = '0;
        if (r_state == S_DONE) begin
          w_ptr_nxt = w_owner_inc;
        end
        if (w_arb_hit) begin
          w_state_nxt = S_ISSUE;
          w_grant_nxt = w_arb_oh;
          w_bsel_nxt  = w_arb_idx;
          w_issue_nxt = 1'b1;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_last) begin
          w_state_nxt = S_DRAIN;
          w_issue_nxt = 1'b0;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end else if (w_row_end) begin
          w_row_nxt = '0;
          w_col_nxt = r_col + 1'b1;
        end else begin
          w_row_nxt = r_row + 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_cap_last) begin
          w_state_nxt = S_DONE;
          w_grant_nxt = '0;
          w_done_nxt  = r_grant;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_bsel  <= '0;
      r_ptr   <= '0;
      r_issue <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_bsel  <= w_bsel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_issue <= w_issue_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Issue tags ride a LAT-deep line to match the datapath latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_dl_vld[i] <= 1'b0;
        r_dl_row[i] <= '0;
        r_dl_col[i] <= '0;
      end
    end else begin
      r_dl_vld[0] <= r_issue;
      r_dl_row[0] <= r_row;
      r_dl_col[0] <= r_col;
      for (int i = 1; i < LAT; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_row[i] <= r_dl_row[i-1];
        r_dl_col[i] <= r_dl_col[i-1];
      end
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign busy      = |r_grant;
  assign bsel      = r_bsel;
  assign addr_rowH = r_row;
  assign addr_colB = r_col;
  assign issue_vld = r_issue;
  assign cap_vld   = r_dl_vld[LAT-1];
  assign cap_row   = r_dl_row[LAT-1];
  assign cap_col   = r_dl_col[LAT-1];

endmodule

// File: tb/tb_hqb_job_sched.sv
// Directed bench for hqb_job_sched: defaults build plus a LAT=1 build.
// Expected values come from the cycle table of a job.
module tb_hqb_job_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] done;
  logic       busy;
  logic [1:0] bsel;
  logic [1:0] arow;
  logic [0:0] acol;
  logic       iss;
  logic       cvld;
  logic [1:0] crow;
  logic [0:0] ccol;

  logic [3:0] req1;
  logic [3:0] grant1;
  logic [3:0] done1;
  logic       busy1;
  logic [1:0] bsel1;
  logic [1:0] arow1;
  logic [0:0] acol1;
  logic       iss1;
  logic       cvld1;
  logic [1:0] crow1;
  logic [0:0] ccol1;

  int checks = 0;
  int errors = 0;

  hqb_job_sched #(.NREQ(4), .NROW(4), .NCOL(2), .LAT(4)) u_dut (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant), .done(done), .busy(busy),
    .bsel(bsel), .addr_rowH(arow), .addr_colB(acol),
    .issue_vld(iss), .cap_vld(cvld),
    .cap_row(crow), .cap_col(ccol)
  );

  hqb_job_sched #(.NREQ(4), .NROW(4), .NCOL(2), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1),
    .grant(grant1), .done(done1), .busy(busy1),
    .bsel(bsel1), .addr_rowH(arow1), .addr_colB(acol1),
    .issue_vld(iss1), .cap_vld(cvld1),
    .cap_row(crow1), .cap_col(ccol1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One default job from cycle 1 to the done cycle 13.
  // At cycle chg (0 = just after E0) req becomes nreq.
  task automatic check_job(input logic [3:0] own,
                           input int bs,
                           input logic [3:0] nreq,
                           input int chg);
    int k;
    if (chg == 0) begin
      @(posedge clk);
      #1 req = nreq;
    end
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("grant c%0d", c), 32'(grant),
          (c <= 12) ? 32'(own) : 32'd0);
      chk($sformatf("busy c%0d", c), 32'(busy),
          (c <= 12) ? 32'd1 : 32'd0);
      chk($sformatf("done c%0d", c), 32'(done),
          (c == 13) ? 32'(own) : 32'd0);
      chk($sformatf("bsel c%0d", c), 32'(bsel), 32'(bs));
      chk($sformatf("iss c%0d", c), 32'(iss),
          (c <= 8) ? 32'd1 : 32'd0);
      chk($sformatf("arow c%0d", c), 32'(arow),
          (c <= 8) ? 32'((c - 1) % 4) : 32'd0);
      chk($sformatf("acol c%0d", c), 32'(acol),
          (c <= 8) ? 32'((c - 1) / 4) : 32'd0);
      chk($sformatf("cvld c%0d", c), 32'(cvld),
          (c >= 5 && c <= 12) ? 32'd1 : 32'd0);
      if (c >= 5 && c <= 12) begin
        k = c - 4;
        chk($sformatf("crow c%0d", c), 32'(crow),
            32'((k - 1) % 4));
        chk($sformatf("ccol c%0d", c), 32'(ccol),
            32'((k - 1) / 4));
      end
      if (c == chg) req = nreq;
    end
  endtask

  task automatic idle(input int n, input int bs);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle grant", 32'(grant), 32'd0);
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle done", 32'(done), 32'd0);
      chk("idle iss", 32'(iss), 32'd0);
      chk("idle cvld", 32'(cvld), 32'd0);
      chk("idle bsel", 32'(bsel), 32'(bs));
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    req1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst bsel", 32'(bsel), 32'd0);
    chk("rst arow", 32'(arow), 32'd0);
    chk("rst acol", 32'(acol), 32'd0);
    chk("rst iss", 32'(iss), 32'd0);
    chk("rst cvld", 32'(cvld), 32'd0);
    chk("rst crow", 32'(crow), 32'd0);
    chk("rst ccol", 32'(ccol), 32'd0);
    rst = 1'b0;
    idle(2, 0);

    // Single job, req held until the done cycle.
    req = 4'b0001;
    check_job(4'b0001, 0, 4'b0000, 13);
    idle(2, 0);

    // One-cycle request still runs a full job.
    req = 4'b0010;
    check_job(4'b0010, 1, 4'b0000, 0);
    idle(3, 1);

    // Owner 2 leaves the pointer at 3; bit 3 clear wraps to bit 0.
    req = 4'b0100;
    check_job(4'b0100, 2, 4'b0101, 13);
    check_job(4'b0001, 0, 4'b0000, 13);
    idle(2, 0);

    // Reset in cycle 6 of a job for owner 2.
    req = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("pre-rst grant c%0d", c),
          32'(grant), 32'b0100);
    end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("mid-rst grant", 32'(grant), 32'd0);
    chk("mid-rst done", 32'(done), 32'd0);
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst bsel", 32'(bsel), 32'd0);
    chk("mid-rst arow", 32'(arow), 32'd0);
    chk("mid-rst acol", 32'(acol), 32'd0);
    chk("mid-rst iss", 32'(iss), 32'd0);
    chk("mid-rst cvld", 32'(cvld), 32'd0);
    rst = 1'b0;
    idle(10, 0);
    // Pointer back at 0: 1001 must pick bit 0, not bit 3.
    req = 4'b1001;
    check_job(4'b0001, 0, 4'b0000, 1);
    idle(2, 0);

    // Round robin with all requests held from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    check_job(4'b0001, 0, 4'b1111, 13);
    check_job(4'b0010, 1, 4'b1111, 13);
    check_job(4'b0100, 2, 4'b1111, 13);
    check_job(4'b1000, 3, 4'b1111, 13);
    check_job(4'b0001, 0, 4'b0000, 13);
    idle(2, 0);

    // LAT=1 build: captures 2..9, done 10.
    req1 = 4'b0001;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("L1 iss c%0d", c), 32'(iss1),
          (c <= 8) ? 32'd1 : 32'd0);
      chk($sformatf("L1 cvld c%0d", c), 32'(cvld1),
          (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 9) begin
        chk($sformatf("L1 crow c%0d", c), 32'(crow1),
            32'((c - 2) % 4));
        chk($sformatf("L1 ccol c%0d", c), 32'(ccol1),
            32'((c - 2) / 4));
      end
      chk($sformatf("L1 done c%0d", c), 32'(done1),
          (c == 10) ? 32'b0001 : 32'd0);
      chk($sformatf("L1 grant c%0d", c), 32'(grant1),
          (c <= 9) ? 32'b0001 : 32'd0);
      if (c == 1) req1 = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
